vga_pixclk_ctrl: RTL and testbench
==================================

# vga_pixclk_ctrl

Run-time controller for the VGA pixel-clock divider. It accepts mode-change requests over a valid/ready handshake and checks each mode against the supported table. A new divide value is loaded only at a half-period boundary, so `div_out` never glitches. After each load the block waits a fixed number of output toggles before asserting `locked`. It sits between the mode-select logic and the timing generators, replacing direct static `mode` wiring into the divider.

## Interface
- `CNT_W`, 32, divider counter/value width
- `VAL_MODE1`, 25175000, half-period in `clk` cycles for mode 4'b0001
- `VAL_MODE5`, 50000000, half-period in `clk` cycles for mode 4'b0101
- `SETTLE_TOGGLES`, 4, `div_out` toggles required after a load before `locked`=1; range 1..255
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `req_valid`  in  1  mode-change request valid
- `req_mode`  in  4  requested mode code
- `req_ready`  out  1  request accepted this cycle when `req_valid`&&`req_ready`
- `req_err`  out  1  one-cycle pulse: accepted request carried an unsupported mode
- `cur_mode`  out  4  mode currently loaded in divider
- `div_out`  out  1  divided clock; toggles every VAL cycles
- `locked`  out  1  divider stable in `cur_mode`

## Operation
- Divider: `cnt` counts 0..VAL-1. At `cnt`==VAL-1: `div_out` inverts and `cnt`<=0. Half-period is exactly VAL cycles.
- Both VAL parameters must be >=2.
- Supported modes: 4'b0001 -> `VAL_MODE1`; 4'b0101 -> `VAL_MODE5`. All other codes are unsupported.
- Reset values: state SETTLE, `cur_mode`=4'b0001, VAL=`VAL_MODE1`, `cnt`=0, `div_out`=0, `locked`=0, `req_ready`=0, `req_err`=0, settle count=0, pending mode cleared.
- State SETTLE:
  - Counts `div_out` toggles.
  - On the SETTLE_TOGGLES-th toggle -> LOCKED.
- State LOCKED:
  - `req_ready`=1; `locked`=1.
  - On handshake with an unsupported mode: `req_err` pulses; state, divider and `cur_mode` are unchanged.
  - On handshake with `req_mode`==`cur_mode`: accepted, no effect, no unlock.
  - Otherwise: latch pending mode -> DRAIN.
- State DRAIN:
  - `req_ready`=0; `locked`=0. Divider keeps running with the old VAL.
  - At terminal count, all in the same edge: `div_out` toggles, `cnt`<=0, VAL<=new value, `cur_mode`<=pending, settle count<=0, state -> SETTLE.
  - The toggle at this DRAIN edge is not counted toward settling.
- `req_valid` outside LOCKED: ignored; no error, no queuing.
- `rst` asserted in any state: immediate return to reset values; a pending mode is dropped.

## Timing
- All outputs are registered.
- `req_ready` and `locked` decode directly from the state register.
- `req_err` is high in the cycle after the accepting edge, for exactly one cycle.
- `locked` falls in the cycle after a mode-changing handshake.
- Accept-to-new-VAL latency equals the remaining cycles of the current half-period (1..old VAL).
- `locked` rises in the cycle after the SETTLE_TOGGLES-th post-load toggle.
- Relock time after load = SETTLE_TOGGLES × new VAL cycles.
- No extra stall cycles: no half-period is ever shorter or longer than its VAL.
- Settle counter width: 8 bits, saturating is unnecessary since it clears on exit.

## Structure
- Shared header `vga_modes.vh`:
  - mode codes `MODE_1`=4'b0001, `MODE_5`=4'b0101
  - FSM state encodings SETTLE/LOCKED/DRAIN
- Sub-module `clk_div_core`:
  - loadable divider holding `cnt`, VAL and `div_out`
  - inputs `load`, `load_val`; output `tc` (terminal count)
  - load takes effect only when asserted with `tc`
- Top-level `vga_pixclk_ctrl` holds the FSM, mode decode, settle counter and handshake.

## Test plan
Bench overrides: `VAL_MODE1`=4, `VAL_MODE5`=6, `SETTLE_TOGGLES`=2.

1. Reset release -> `div_out` toggles at edges 4 and 8; `locked`=1 and `req_ready`=1 from edge 8; `cur_mode`=4'b0001.
2. In LOCKED at `cnt`=1, request 4'b0101:
   - `locked`=0 next cycle.
   - `div_out` toggles 3 cycles after accept with `cur_mode`=4'b0101.
   - Subsequent half-periods are 6 cycles.
   - `locked`=1 after 12 further cycles.
3. Request 4'b0010 in LOCKED -> `req_err` is a single-cycle pulse; `cur_mode`, `locked` and `div_out` cadence are unchanged.
4. Request 4'b0001 while in mode 1 -> accepted (`req_ready`=1), `locked` stays 1, no `req_err`, cadence unchanged.
5. Assert `rst` mid-DRAIN -> all outputs take reset values without waiting for a clock edge; `cur_mode`=4'b0001; the pending 4'b0101 never takes effect.
6. `req_valid` held with 4'b0101 during SETTLE -> no acceptance until LOCKED; accepted on the first LOCKED cycle, then the normal DRAIN sequence follows.

Source files
------------

// File: rtl/vga_pixclk_ctrl_pkg.sv
// Shared definitions for the VGA pixel-clock controller: mode codes,
// FSM state encoding and the supported-mode decode.
package vga_pixclk_ctrl_pkg;

    localparam logic [3:0] MODE_1 = 4'b0001;
    localparam logic [3:0] MODE_5 = 4'b0101;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_LOCKED = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    function automatic logic mode_supported(input logic [3:0] mode);
        return (mode == MODE_1) || (mode == MODE_5);
    endfunction

endpackage

// File: rtl/vga_pixclk_ctrl_clk_div_core.sv
// Loadable half-period divider. A new VAL is only taken on the terminal-count
// edge, so every half-period of div_o is exactly one full VAL long.
module clk_div_core #(
    parameter int               CNT_W   = 32,
    parameter logic [CNT_W-1:0] RST_VAL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o,
    output logic             div_o
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] val_q;
    logic             div_q;

    assign tc_o  = (cnt_q == val_q - ONE);
    assign div_o = div_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            val_q <= RST_VAL;
            div_q <= 1'b0;
        end else if (tc_o) begin
            cnt_q <= '0;
            div_q <= ~div_q;
            if (load_i) begin
                val_q <= load_val_i;
            end
        end else begin
            cnt_q <= cnt_q + ONE;
        end
    end

endmodule

// File: rtl/vga_pixclk_ctrl.sv
// Run-time pixel-clock mode controller: handshake, mode check, glitch-free
// divider reload at a half-period boundary, and settle-before-lock tracking.
module vga_pixclk_ctrl
    import vga_pixclk_ctrl_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int VAL_MODE1      = 25175000,
    parameter int VAL_MODE5      = 50000000,
    parameter int SETTLE_TOGGLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid_i,
    input  logic [3:0] req_mode_i,
    output logic       req_ready_o,
    output logic       req_err_o,
    output logic [3:0] cur_mode_o,
    output logic       div_out_o,
    output logic       locked_o
);

    localparam logic [CNT_W-1:0] VAL1     = CNT_W'(VAL_MODE1);
    localparam logic [CNT_W-1:0] VAL5     = CNT_W'(VAL_MODE5);
    localparam logic [7:0]       SETTLE_N = 8'(SETTLE_TOGGLES);

    state_e     state_q, state_d;
    logic [3:0] cur_mode_q, cur_mode_d;
    logic [3:0] pend_q, pend_d;
    logic [7:0] settle_q, settle_d;
    logic       err_q, err_d;
    logic       load;
    logic       tc;
    logic [CNT_W-1:0] load_val;

    assign load_val = (pend_q == MODE_5) ? VAL5 : VAL1;

    clk_div_core #(
        .CNT_W   (CNT_W),
        .RST_VAL (VAL1)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_val_i (load_val),
        .tc_o       (tc),
        .div_o      (div_out_o)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cur_mode_d = cur_mode_q;
        pend_d     = pend_q;
        settle_d   = settle_q;
        err_d      = 1'b0;
        load       = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                if (tc) begin
                    settle_d = settle_q + 8'd1;
                    if (settle_q + 8'd1 == SETTLE_N) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (req_valid_i) begin
                    if (!mode_supported(req_mode_i)) begin
                        err_d = 1'b1;
                    end else if (req_mode_i != cur_mode_q) begin
                        pend_d  = req_mode_i;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The reload edge toggles div_out but does not count toward settling.
                load = tc;
                if (tc) begin
                    cur_mode_d = pend_q;
                    settle_d   = 8'd0;
                    state_d    = ST_SETTLE;
                end
            end
            default: state_d = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SETTLE;
            cur_mode_q <= MODE_1;
            pend_q     <= '0;
            settle_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_mode_q <= cur_mode_d;
            pend_q     <= pend_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
        end
    end

    assign req_ready_o = (state_q == ST_LOCKED);
    assign locked_o    = (state_q == ST_LOCKED);
    assign req_err_o   = err_q;
    assign cur_mode_o  = cur_mode_q;

endmodule

// File: tb/tb_vga_pixclk_ctrl.sv
// Directed bench for vga_pixclk_ctrl with VAL_MODE1=4, VAL_MODE5=6,
// SETTLE_TOGGLES=2; expected cadences are hand-derived edge counts.
module tb_vga_pixclk_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_mode = 4'b0000;
    logic       req_ready;
    logic       req_err;
    logic [3:0] cur_mode;
    logic       div_out;
    logic       locked;

    int n_checks = 0;
    int n_fail   = 0;

    vga_pixclk_ctrl #(
        .CNT_W          (32),
        .VAL_MODE1      (4),
        .VAL_MODE5      (6),
        .SETTLE_TOGGLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_mode_i  (req_mode),
        .req_ready_o (req_ready),
        .req_err_o   (req_err),
        .cur_mode_o  (cur_mode),
        .div_out_o   (div_out),
        .locked_o    (locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one half-period of n edges: div_out and locked hold for n-1
    // edges, then div_out toggles on the n-th.
    task automatic expect_half(input int n, input logic exp_lock_mid, input string name);
        logic start;
        start = div_out;
        for (int i = 1; i < n; i++) begin
            tick();
            n_checks++;
            if (div_out !== start || locked !== exp_lock_mid) begin
                n_fail++;
                $display("FAIL %s edge %0d: div_out=%b locked=%b, expected div_out=%b locked=%b",
                         name, i, div_out, locked, start, exp_lock_mid);
            end
        end
        tick();
        n_checks++;
        if (div_out !== ~start) begin
            n_fail++;
            $display("FAIL %s edge %0d: div_out=%b, expected toggle to %b", name, n, div_out, ~start);
        end
    endtask

    // Compares {req_ready, locked, req_err, cur_mode} against an expected tuple.
    task automatic expect_status(input logic rdy, input logic lck, input logic err,
                                 input logic [3:0] mode, input string name);
        n_checks++;
        if ({req_ready, locked, req_err, cur_mode} !== {rdy, lck, err, mode}) begin
            n_fail++;
            $display("FAIL %s: ready=%b locked=%b err=%b mode=%b, expected ready=%b locked=%b err=%b mode=%b",
                     name, req_ready, locked, req_err, cur_mode, rdy, lck, err, mode);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        expect_status(1'b0, 1'b0, 1'b0, 4'b0001, "reset_hold");
        n_checks++;
        if (div_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_div: div_out=%b, expected 0", div_out);
        end
        rst = 1'b0;
        expect_half(4, 1'b0, "reset_first_half");
        expect_status(1'b0, 1'b0, 1'b0, 4'b0001, "after_first_toggle");
        expect_half(4, 1'b0, "reset_second_half");
        expect_status(1'b1, 1'b1, 1'b0, 4'b0001, "locked_at_edge8");
    endtask

    task automatic test_same_mode();
        req_valid = 1'b1;
        req_mode  = 4'b0001;
        expect_status(1'b1, 1'b1, 1'b0, 4'b0001, "same_mode_ready");
        tick();
        req_valid = 1'b0;
        expect_status(1'b1, 1'b1, 1'b0, 4'b0001, "same_mode_accept");
        tick();
        expect_status(1'b1, 1'b1, 1'b0, 4'b0001, "same_mode_no_err");
        expect_half(2, 1'b1, "same_mode_cadence");
        expect_half(4, 1'b1, "same_mode_next_half");
    endtask

    task automatic test_mode_change();
        tick();
        req_valid = 1'b1;
        req_mode  = 4'b0101;
        tick();
        req_valid = 1'b0;
        expect_status(1'b0, 1'b0, 1'b0, 4'b0001, "change_unlock");
        expect_half(2, 1'b0, "change_drain");
        expect_status(1'b0, 1'b0, 1'b0, 4'b0101, "change_loaded");
        expect_half(6, 1'b0, "mode5_half1");
        expect_half(6, 1'b0, "mode5_half2");
        expect_status(1'b1, 1'b1, 1'b0, 4'b0101, "mode5_relock");
    endtask

    task automatic test_unsupported();
        tick();
        req_valid = 1'b1;
        req_mode  = 4'b0010;
        tick();
        req_valid = 1'b0;
        expect_status(1'b1, 1'b1, 1'b1, 4'b0101, "unsup_err_pulse");
        tick();
        expect_status(1'b1, 1'b1, 1'b0, 4'b0101, "unsup_err_cleared");
        expect_half(3, 1'b1, "unsup_cadence");
        expect_half(6, 1'b1, "unsup_next_half");
        expect_status(1'b1, 1'b1, 1'b0, 4'b0101, "unsup_final");
    endtask

    task automatic test_reset_mid_drain();
        rst = 1'b1;
        #1;
        expect_status(1'b0, 1'b0, 1'b0, 4'b0001, "reset_from_mode5");
        tick();
        rst = 1'b0;
        expect_half(4, 1'b0, "drain_pre_half1");
        expect_half(4, 1'b0, "drain_pre_half2");
        expect_half(4, 1'b1, "drain_pre_half3");
        tick();
        req_valid = 1'b1;
        req_mode  = 4'b0101;
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++;
        if ({div_out, locked} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_drain_pre: div_out=%b locked=%b, expected div_out=1 locked=0", div_out, locked);
        end
        rst = 1'b1;
        #1;
        expect_status(1'b0, 1'b0, 1'b0, 4'b0001, "async_reset_status");
        n_checks++;
        if (div_out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_div: div_out=%b, expected 0", div_out);
        end
        tick();
        tick();
        expect_status(1'b0, 1'b0, 1'b0, 4'b0001, "reset_held");
        rst = 1'b0;
        expect_half(4, 1'b0, "post_reset_half1");
        expect_status(1'b0, 1'b0, 1'b0, 4'b0001, "pending_dropped");
        expect_half(4, 1'b0, "post_reset_half2");
        expect_status(1'b1, 1'b1, 1'b0, 4'b0001, "post_reset_locked");
    endtask

    task automatic test_settle_hold();
        rst = 1'b1;
        tick();
        req_valid = 1'b1;
        req_mode  = 4'b0101;
        rst = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            expect_status(1'b0, 1'b0, 1'b0, 4'b0001, "settle_ignore");
            n_checks++;
            if (div_out !== (i >= 4)) begin
                n_fail++;
                $display("FAIL settle_div edge %0d: div_out=%b, expected %b", i, div_out, (i >= 4));
            end
        end
        tick();
        expect_status(1'b1, 1'b1, 1'b0, 4'b0001, "settle_first_locked");
        tick();
        req_valid = 1'b0;
        expect_status(1'b0, 1'b0, 1'b0, 4'b0001, "settle_accept");
        expect_half(3, 1'b0, "settle_drain");
        expect_status(1'b0, 1'b0, 1'b0, 4'b0101, "settle_loaded");
        expect_half(6, 1'b0, "settle_mode5_half1");
        expect_half(6, 1'b0, "settle_mode5_half2");
        expect_status(1'b1, 1'b1, 1'b0, 4'b0101, "settle_relock");
    endtask

    initial begin
        test_reset();
        test_same_mode();
        test_mode_change();
        test_unsupported();
        test_reset_mid_drain();
        test_settle_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
